ling_seq_adder64_ctrl: RTL and testbench

Sequential 64-bit add/subtract controller that reuses a single 16-bit Ling CLA slice over four cycles, least-significant slice first.
- Upstream of the slice: latches operands and forms per-bit p = a^b, g = a&b for the active slice, then drives the slice's cin, p and g.
- Downstream of the slice: converts the returned Ling pseudo-carries h[16:1] into true carries and sum bits, then registers the slice carry-out into the next slice's cin.
- Gives area-constrained datapaths a 64-bit adder at the cost of one 16-bit slice.

---
 rtl/ling_seq_adder64_ctrl.sv | 147 ++++++++++++++
 tb/tb_ling_seq_adder64_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ling_seq_adder64_ctrl.sv
// Sequential 64-bit add/subtract that time-multiplexes one external 16-bit Ling CLA slice,
// least-significant slice first, and turns the slice's pseudo-carries into true carries.
`timescale 1ns/1ps
module ling_seq_adder64_ctrl #(
  parameter int SLICE_W  = 16,
  parameter int N_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          sub,
  input  logic [SLICE_W*N_SLICES-1:0]   a,
  input  logic [SLICE_W*N_SLICES-1:0]   b,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [SLICE_W*N_SLICES-1:0]   sum,
  output logic                          cout,
  output logic                          ovf,
  output logic                          cla_cin,
  output logic [SLICE_W-1:0]            cla_p,
  output logic [SLICE_W-1:0]            cla_g,
  input  logic [SLICE_W-1:0]            cla_h,
  input  logic                          cla_P,
  input  logic                          cla_G
);

  localparam int W     = SLICE_W * N_SLICES;
  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SLICE_W-1:0] slice_a, slice_b;
  logic [SLICE_W-1:0] t;
  logic [SLICE_W:0]   c;
  logic [SLICE_W-1:0] s;

  // Block-level P/G are not needed: true carries come from the per-bit h terms.
  logic unused_slice_pg;
  assign unused_slice_pg = cla_P ^ cla_G;

  // Slice drive is kept apart from carry recovery so cla_p -> cla_h -> c is not a block-level loop.
  always_comb begin
    slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
    cla_p   = '0;
    cla_g   = '0;
    cla_cin = 1'b0;
    if (state_q == S_RUN) begin
      cla_p   = slice_a ^ slice_b;
      cla_g   = slice_a & slice_b;
      cla_cin = carry_q;
    end
  end

  // cla_h[j] carries h[j+1]; a true carry needs the local t to qualify the pseudo-carry.
  always_comb begin
    t    = cla_p | cla_g;
    c    = '0;
    c[0] = carry_q;
    for (int j = 0; j < SLICE_W; j++) begin
      c[j+1] = t[j] & cla_h[j];
    end
    s = cla_p ^ c[SLICE_W-1:0];
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no path leaves one unassigned and no latch appears.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {W{sub}};
          carry_d = sub | cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = s;
        carry_d = c[SLICE_W];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = c[SLICE_W];
          ovf_d   = c[SLICE_W-1] ^ c[SLICE_W];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_ling_seq_adder64_ctrl.sv
// Bench for ling_seq_adder64_ctrl: behavioural Ling slice, vector table, random vectors checked
// by a scoreboard on done, plus hand sequences for carry hand-off, ignored start and reset abort.
`timescale 1ns/1ps
module tb_ling_seq_adder64_ctrl;

  typedef struct {
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, cin;
  logic [63:0] a, b;
  logic        busy, done, cout, ovf;
  logic [63:0] sum;
  logic        cla_cin;
  logic [15:0] cla_p, cla_g, cla_h;
  logic        cla_P, cla_G;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t mon_e;
  vec_t tbl[10];

  always #5 clk = ~clk;

  ling_seq_adder64_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .cla_cin(cla_cin), .cla_p(cla_p), .cla_g(cla_g), .cla_h(cla_h),
    .cla_P(cla_P), .cla_G(cla_G)
  );

  // Behavioural 16-bit Ling slice: h[j+1] = g[j] | (t[j-1] & h[j]), with h at bit 0 = cin.
  always_comb begin
    logic hp, tp;
    hp = cla_cin;
    tp = 1'b1;
    cla_h = '0;
    for (int j = 0; j < 16; j++) begin
      cla_h[j] = cla_g[j] | (tp & hp);
      hp = cla_h[j];
      tp = cla_p[j] | cla_g[j];
    end
    cla_P = &(cla_p | cla_g);
    cla_G = cla_h[15];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input logic s, input logic [63:0] x, input logic [63:0] y,
                                 input logic ci);
    vec_t        v;
    logic [63:0] yy;
    logic [64:0] r;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {64'd0, (s ? 1'b1 : ci)};
    v.sub = s; v.a = x; v.b = y; v.cin = ci;
    v.sum  = r[63:0];
    v.cout = r[64];
    v.ovf  = (x[63] == yy[63]) && (r[63] != x[63]);
    return v;
  endfunction

  // Scoreboard: every done pops the oldest accepted operation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sum", sum, mon_e.sum);
        check("cout", {63'd0, cout}, {63'd0, mon_e.cout});
        check("ovf", {63'd0, ovf}, {63'd0, mon_e.ovf});
        check("busy_in_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic issue(input vec_t v);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
    sb.push_back(v);
  endtask

  // Called at a negedge; e = edges elapsed since (and including) the accepting edge.
  task automatic wait_rest(input int e0);
    int e;
    e = e0;
    while (done !== 1'b1 && e < 20) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
    check("latency", 64'(e), 64'd5);
  endtask

  // Called right after issue() at a negedge; scrambles inputs after acceptance.
  task automatic wait_done();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    sub = 1'($urandom); cin = 1'($urandom);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_rest(1);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    issue(v);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

    tbl[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
    check("rst_cla_drive", {47'd0, cla_cin, cla_p}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cla_g", {48'd0, cla_g}, 64'd0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      v = model(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      run_vec(v);
    end

    // Carry out of slice 0 must be handed to slice 1 as cla_cin.
    @(negedge clk);
    issue(model(1'b0, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("s0_cla_cin", {63'd0, cla_cin}, 64'd1);
    check("s0_cla_p", {48'd0, cla_p}, 64'h0000_0000_0000_FFFF);
    check("s0_cla_g", {48'd0, cla_g}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("s1_cla_cin", {63'd0, cla_cin}, 64'd1);
    check("s1_cla_p", {48'd0, cla_p}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("s2_cla_cin", {63'd0, cla_cin}, 64'd0);
    wait_rest(3);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    issue(model(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 64'hDEAD_BEEF_0000_0000; b = 64'h0000_0000_CAFE_F00D; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_rest(3);
    issue(model(1'b1, 64'h0000_0001_0000_0000, 64'h1, 1'b0));
    wait_done();

    // Reset during slice 2 aborts immediately and produces no done.
    @(negedge clk);
    issue(model(1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_sum", sum, 64'd0);
    check("abort_cout_ovf", {62'd0, cout, ovf}, 64'd0);
    check("abort_cla_cin", {63'd0, cla_cin}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_busy", {63'd0, busy}, 64'd0);
    run_vec(model(1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0));

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
